// File: rtl/divn_sched_if.sv
// Divisor-update port shared by two requesters: request/divisor in, one-cycle grants out.
interface divn_sched_if #(
    parameter int DIV_W = 4
);
    logic             req0;
    logic [DIV_W-1:0] div0;
    logic             req1;
    logic [DIV_W-1:0] div1;
    logic             gnt0;
    logic             gnt1;

    modport master (
        output req0, div0, req1, div1,
        input  gnt0, gnt1
    );

    modport slave (
        input  req0, div0, req1, div1,
        output gnt0, gnt1
    );
endinterface

// File: rtl/divn_sched.sv
// Programmable divide-by-N phase counter whose divisor is updated through a
// round-robin arbitrated port and only takes effect at a period boundary.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | no update outstanding; a request is granted on the next edge
//   S_PENDING | pend_div_q captured, waiting for wrap (en=1) or en=0 to apply
module divn_sched #(
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    divn_sched_if.slave      upd,
    output logic             y,
    output logic             tick,
    output logic [DIV_W-1:0] phase,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [DIV_W-1:0] phase_q,   phase_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             last_q,    last_d;
    logic             gnt0_q,    gnt0_d;
    logic             gnt1_q,    gnt1_d;
    logic             tick_q,    tick_d;
    logic             busy_q,    busy_d;

    logic             at_end;
    logic             apply;
    logic             pick1;
    logic [DIV_W-1:0] sel_div;

    always_comb begin
        at_end  = (phase_q == (cur_div_q - ONE));
        apply   = (state_q == S_PENDING) && (!en || at_end);
        // last_q=1 means requester 1 won last time, so requester 0 wins a tie
        pick1   = upd.req1 && (!upd.req0 || !last_q);
        sel_div = pick1 ? upd.div1 : upd.div0;

        state_d    = state_q;
        phase_d    = phase_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        tick_d     = en && at_end;

        if (apply) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = at_end ? '0 : (phase_q + ONE);
        end

        if (apply) begin
            state_d   = S_IDLE;
            cur_div_d = pend_div_q;
        end else if ((state_q == S_IDLE) && (upd.req0 || upd.req1)) begin
            state_d    = S_PENDING;
            gnt0_d     = !pick1;
            gnt1_d     = pick1;
            last_d     = pick1;
            // a zero divisor would never wrap; treat it as divide-by-1
            pend_div_d = (sel_div == '0) ? ONE : sel_div;
        end

        busy_d = (state_d == S_PENDING);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= DEF_DIV;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
        end
    end

    assign upd.gnt0 = gnt0_q;
    assign upd.gnt1 = gnt1_q;
    assign y        = (phase_q == '0);
    assign tick     = tick_q;
    assign phase    = phase_q;
    assign cur_div  = cur_div_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_divn_sched.sv
// Directed bench for divn_sched: reset state, free-run, arbitrated updates,
// en=0 forced apply and reset while an update is pending.
module tb_divn_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       y;
    logic       tick;
    logic [3:0] phase;
    logic [3:0] cur_div;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    divn_sched_if #(.DIV_W(4)) upd ();

    divn_sched #(.DIV_W(4), .DEFAULT_DIV(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .upd     (upd.slave),
        .y       (y),
        .tick    (tick),
        .phase   (phase),
        .cur_div (cur_div),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("gnt_overlap", 32'(upd.gnt0 & upd.gnt1), 0);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        en       = 1'b0;
        upd.req0 = 1'b0;
        upd.req1 = 1'b0;
        upd.div0 = '0;
        upd.div1 = '0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        upd.req0 = 1'b0;
        upd.req1 = 1'b0;
        upd.div0 = '0;
        upd.div1 = '0;

        // reset values and free run at the default divide-by-3
        do_reset();
        chk("rst_phase", 32'(phase), 0);
        chk("rst_cur_div", 32'(cur_div), 3);
        chk("rst_y", 32'(y), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_gnt0", 32'(upd.gnt0), 0);
        chk("rst_gnt1", 32'(upd.gnt1), 0);
        chk("rst_busy", 32'(busy), 0);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            chk("run_y", 32'(y), 32'(i % 3 == 0));
            chk("run_tick", 32'(tick), 32'(i > 0 && i % 3 == 0));
            chk("run_cur_div", 32'(cur_div), 3);
        end

        // mid-period update to divide-by-5
        do_reset();
        en = 1'b1;
        step();
        chk("mid_phase1", 32'(phase), 1);
        upd.req0 = 1'b1;
        upd.div0 = 4'd5;
        step();
        chk("mid_gnt0", 32'(upd.gnt0), 1);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_phase2", 32'(phase), 2);
        chk("mid_div_old", 32'(cur_div), 3);
        upd.req0 = 1'b0;
        step();
        chk("mid_gnt0_low", 32'(upd.gnt0), 0);
        chk("mid_wrap_phase", 32'(phase), 0);
        chk("mid_cur_div", 32'(cur_div), 5);
        chk("mid_busy_low", 32'(busy), 0);
        chk("mid_tick", 32'(tick), 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("mid_y5", 32'(y), 32'(k % 5 == 0));
            chk("mid_phase5", 32'(phase), 32'(k % 5));
        end

        // simultaneous requests: round robin, starting with requester 0
        do_reset();
        en       = 1'b1;
        upd.req0 = 1'b1;
        upd.req1 = 1'b1;
        upd.div0 = 4'd2;
        upd.div1 = 4'd4;
        step();
        chk("tie_gnt0", 32'(upd.gnt0), 1);
        chk("tie_gnt1_a", 32'(upd.gnt1), 0);
        chk("tie_busy", 32'(busy), 1);
        upd.req0 = 1'b0;
        step();
        chk("tie_pend_gnt1", 32'(upd.gnt1), 0);
        chk("tie_pend_phase", 32'(phase), 2);
        step();
        chk("tie_apply_div", 32'(cur_div), 2);
        chk("tie_apply_phase", 32'(phase), 0);
        chk("tie_apply_gnt1", 32'(upd.gnt1), 0);
        chk("tie_apply_busy", 32'(busy), 0);
        step();
        chk("tie_gnt1", 32'(upd.gnt1), 1);
        chk("tie_gnt0_b", 32'(upd.gnt0), 0);
        chk("tie_phase_b", 32'(phase), 1);
        upd.req1 = 1'b0;
        step();
        chk("tie_div4", 32'(cur_div), 4);
        chk("tie_phase_c", 32'(phase), 0);
        upd.req0 = 1'b1;
        upd.req1 = 1'b1;
        upd.div0 = 4'd6;
        upd.div1 = 4'd9;
        step();
        chk("tie2_gnt0", 32'(upd.gnt0), 1);
        chk("tie2_gnt1", 32'(upd.gnt1), 0);
        upd.req0 = 1'b0;
        upd.req1 = 1'b0;

        // apply forced by en=0, divisor 0 loads as 1
        do_reset();
        en = 1'b1;
        step();
        step();
        chk("en0_phase2", 32'(phase), 2);
        en       = 1'b0;
        upd.req1 = 1'b1;
        upd.div1 = 4'd0;
        step();
        chk("en0_gnt1", 32'(upd.gnt1), 1);
        chk("en0_hold", 32'(phase), 2);
        upd.req1 = 1'b0;
        step();
        chk("en0_phase0", 32'(phase), 0);
        chk("en0_cur_div", 32'(cur_div), 1);
        chk("en0_tick", 32'(tick), 0);
        chk("en0_busy", 32'(busy), 0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("div1_y", 32'(y), 1);
            chk("div1_phase", 32'(phase), 0);
        end

        // reset while an update is pending
        do_reset();
        en       = 1'b1;
        upd.req0 = 1'b1;
        upd.div0 = 4'd7;
        step();
        chk("rp_gnt0", 32'(upd.gnt0), 1);
        chk("rp_busy", 32'(busy), 1);
        reset = 1'b0;
        step();
        chk("rp_cur_div", 32'(cur_div), 3);
        chk("rp_busy_low", 32'(busy), 0);
        chk("rp_gnt0_low", 32'(upd.gnt0), 0);
        chk("rp_phase", 32'(phase), 0);
        step();
        chk("rp_no_grant", 32'(upd.gnt0), 0);
        reset = 1'b1;
        step();
        chk("rp_regrant", 32'(upd.gnt0), 1);
        chk("rp_busy2", 32'(busy), 1);
        chk("rp_div_kept", 32'(cur_div), 3);
        upd.req0 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
